// File: rtl/mux4_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux4_arbiter_if
//   Bundle of the request and output-channel signals of mux4_arbiter.
//
//   req[3:0]      requester i has a valid beat on in_i
//   in0..in3      requester data, N bits each
//   ack[3:0]      requester i's beat accepted this cycle
//   out_valid     out_data holds a valid beat
//   out_ready     downstream accepts the beat this cycle
//   out_data      steered requester data
//   select        current or last grant index
//   busy          arbiter is holding a grant
//
//   master : the requester/downstream side (drives req, in*, out_ready)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface mux4_arbiter_if #(
  parameter int N = 8
);
  logic [3:0]   req;
  logic [N-1:0] in0;
  logic [N-1:0] in1;
  logic [N-1:0] in2;
  logic [N-1:0] in3;
  logic [3:0]   ack;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic [1:0]   select;
  logic         busy;

  modport master (
    output req, in0, in1, in2, in3, out_ready,
    input  ack, out_valid, out_data, select, busy
  );

  modport slave (
    input  req, in0, in1, in2, in3, out_ready,
    output ack, out_valid, out_data, select, busy
  );
endinterface

// File: rtl/mux4_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_arbiter
//   Round-robin arbiter sharing one N-bit output channel among four
//   requesters. The winner's index drives the select of a mux4 that steers
//   its data to the output; valid/ready passes through. A grant lasts at most
//   MAX_BURST accepted beats, then the arbiter releases for re-arbitration.
//
//   Ports:
//     clk   system clock, all state on rising edge
//     rst   synchronous active-high reset
//     bus   mux4_arbiter_if.slave (req, in0..in3, ack, out_valid,
//           out_ready, out_data, select, busy)
//
//   Parameters:
//     N          data width
//     MAX_BURST  accepted beats per grant, 1..255
// ---------------------------------------------------------------------------

// Plain 4:1 multiplexer.
module mux4 #(
  parameter int N = 8
) (
  input  logic [1:0]   sel,
  input  logic [N-1:0] d0,
  input  logic [N-1:0] d1,
  input  logic [N-1:0] d2,
  input  logic [N-1:0] d3,
  output logic [N-1:0] y
);
  always_comb begin
    y = d0;
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end
endmodule

module mux4_arbiter #(
  parameter int N         = 8,
  parameter int MAX_BURST = 4
) (
  input logic           clk,
  input logic           rst,
  mux4_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  state_t       state_reg;
  logic [1:0]   select_reg;
  logic [7:0]   count_reg;
  logic         busy_reg;

  logic [1:0]   winner;
  logic         holder_req;
  logic         out_valid;
  logic         accept;
  logic [3:0]   ack_vec;
  logic [N-1:0] mux_y;

  // Round-robin search starting at the neighbour of the last winner; the
  // last winner itself is checked last so it loses to any other requester.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    winner = select_reg;
    found  = 1'b0;
    idx    = select_reg;
    for (int k = 1; k <= 4; k++) begin
      idx = select_reg + k[1:0];
      if (!found && bus.req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign holder_req = bus.req[select_reg];
  assign out_valid  = (state_reg == GRANT) && holder_req;
  assign accept     = out_valid && bus.out_ready;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ack
      assign ack_vec[gi] = accept && (select_reg == 2'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      select_reg <= 2'b11;
      count_reg  <= 8'd0;
      busy_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|bus.req) begin
            select_reg <= winner;
            count_reg  <= 8'd0;
            state_reg  <= GRANT;
            busy_reg   <= 1'b1;
          end
        end
        GRANT: begin
          if (!holder_req) begin
            // Holder withdrew: end the grant, keep select as last winner.
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (accept) begin
            if (count_reg == LAST_BEAT) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
              count_reg <= 8'd0;
            end else begin
              count_reg <= count_reg + 8'd1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  mux4 #(.N(N)) u_mux4 (
    .sel (select_reg),
    .d0  (bus.in0),
    .d1  (bus.in1),
    .d2  (bus.in2),
    .d3  (bus.in3),
    .y   (mux_y)
  );

  assign bus.out_data  = mux_y;
  assign bus.out_valid = out_valid;
  assign bus.ack       = ack_vec;
  assign bus.select    = select_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_mux4_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux4_arbiter
//   Directed bench for mux4_arbiter. One DUT with MAX_BURST=4, a second with
//   MAX_BURST=1. Inputs change 1 ns after the rising edge; outputs are
//   sampled 1 ns later, well before the next edge.
// ---------------------------------------------------------------------------
module tb_mux4_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mux4_arbiter_if #(.N(8)) bus ();
  mux4_arbiter_if #(.N(8)) bus1 ();

  mux4_arbiter #(.N(8), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  mux4_arbiter #(.N(8), .MAX_BURST(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus1.req = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.in3 = 8'h3C;
    do_reset();
    settle();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy actual=%b required=0", bus.busy);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid actual=%b required=0", bus.out_valid);
    end
    checks++;
    if (bus.ack !== 4'b0000) begin
      failures++; $display("FAIL reset_ack actual=%b required=0000", bus.ack);
    end
    checks++;
    if (bus.select !== 2'd3) begin
      failures++; $display("FAIL reset_select actual=%0d required=3", bus.select);
    end
    checks++;
    if (bus.out_data !== 8'h3C) begin
      failures++; $display("FAIL reset_out_data actual=%h required=3c", bus.out_data);
    end
    $display("test_reset: done");
  endtask

  task automatic test_single();
    bus.in0       = 8'hA5;
    bus.out_ready = 1'b1;
    bus.req       = 4'b0001;
    settle();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL single_c0_valid actual=%b required=0", bus.out_valid);
    end
    tick();
    checks++;
    if (bus.select !== 2'd0 || bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin
      failures++;
      $display("FAIL single_c1 actual sel=%0d valid=%b data=%h required sel=0 valid=1 data=a5",
               bus.select, bus.out_valid, bus.out_data);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.ack !== 4'b0001) begin
        failures++; $display("FAIL single_beat%0d_ack actual=%b required=0001", i, bus.ack);
      end
      tick();
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.ack !== 4'b0000) begin
      failures++;
      $display("FAIL single_bubble actual busy=%b ack=%b required busy=0 ack=0000", bus.busy, bus.ack);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.select !== 2'd0 || bus.ack !== 4'b0001) begin
      failures++;
      $display("FAIL single_regrant actual busy=%b sel=%0d ack=%b required busy=1 sel=0 ack=0001",
               bus.busy, bus.select, bus.ack);
    end
    bus.req = 4'b0000;
    settle();
    checks++;
    if (bus.ack !== 4'b0000) begin
      failures++; $display("FAIL single_drop_ack actual=%b required=0000", bus.ack);
    end
    tick();
    $display("test_single: done");
  endtask

  task automatic test_round_robin();
    int         acks [4];
    logic [3:0] exp_ack;
    do_reset();
    for (int i = 0; i < 4; i++) acks[i] = 0;
    bus.out_ready = 1'b1;
    bus.req       = 4'b1111;
    // Each grant takes 5 cycles: one arbitration cycle, four beats.
    for (int c = 0; c < 40; c++) begin
      settle();
      exp_ack = (c % 5 == 0) ? 4'b0000 : (4'b0001 << ((c / 5) % 4));
      checks++;
      if (bus.ack !== exp_ack) begin
        failures++; $display("FAIL rr_cycle%0d_ack actual=%b required=%b", c, bus.ack, exp_ack);
      end
      for (int i = 0; i < 4; i++) if (bus.ack[i] === 1'b1) acks[i]++;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (acks[i] != 8) begin
        failures++; $display("FAIL rr_total_req%0d actual=%0d required=8", i, acks[i]);
      end
    end
    bus.req = 4'b0000;
    tick();
    tick();
    $display("test_round_robin: done");
  endtask

  task automatic test_stall();
    do_reset();
    bus.in2       = 8'h77;
    bus.out_ready = 1'b1;
    bus.req       = 4'b0100;
    tick();
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (bus.ack !== 4'b0100 || bus.out_data !== 8'h77) begin
        failures++;
        $display("FAIL stall_pre_beat%0d actual ack=%b data=%h required ack=0100 data=77",
                 b, bus.ack, bus.out_data);
      end
      tick();
    end
    bus.out_ready = 1'b0;
    for (int s = 0; s < 10; s++) begin
      settle();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.ack !== 4'b0000 || bus.select !== 2'd2) begin
        failures++;
        $display("FAIL stall_cycle%0d actual valid=%b ack=%b sel=%0d required valid=1 ack=0000 sel=2",
                 s, bus.out_valid, bus.ack, bus.select);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    for (int b = 2; b < 4; b++) begin
      settle();
      checks++;
      if (bus.ack !== 4'b0100) begin
        failures++; $display("FAIL stall_post_beat%0d actual ack=%b required=0100", b, bus.ack);
      end
      tick();
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.ack !== 4'b0000) begin
      failures++;
      $display("FAIL stall_release actual busy=%b ack=%b required busy=0 ack=0000", bus.busy, bus.ack);
    end
    bus.req = 4'b0000;
    tick();
    $display("test_stall: done");
  endtask

  task automatic test_drop();
    do_reset();
    bus.in1       = 8'h11;
    bus.in3       = 8'h33;
    bus.out_ready = 1'b1;
    bus.req       = 4'b1010;
    tick();
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (bus.ack !== 4'b0010) begin
        failures++; $display("FAIL drop_beat%0d actual ack=%b required=0010", b, bus.ack);
      end
      tick();
    end
    bus.req = 4'b1000;
    settle();
    checks++;
    if (bus.ack !== 4'b0000 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drop_same_cycle actual ack=%b valid=%b required ack=0000 valid=0", bus.ack, bus.out_valid);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.ack !== 4'b0000) begin
      failures++;
      $display("FAIL drop_idle actual busy=%b ack=%b required busy=0 ack=0000", bus.busy, bus.ack);
    end
    tick();
    checks++;
    if (bus.select !== 2'd3 || bus.ack !== 4'b1000 || bus.out_data !== 8'h33) begin
      failures++;
      $display("FAIL drop_regrant actual sel=%0d ack=%b data=%h required sel=3 ack=1000 data=33",
               bus.select, bus.ack, bus.out_data);
    end
    bus.req = 4'b0000;
    tick();
    $display("test_drop: done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.out_ready = 1'b1;
    bus.req       = 4'b0010;
    tick();
    tick();
    tick();
    // Two beats accepted; a third is on the bus when reset arrives.
    checks++;
    if (bus.select !== 2'd1 || bus.ack !== 4'b0010) begin
      failures++;
      $display("FAIL midrst_pre actual sel=%0d ack=%b required sel=1 ack=0010", bus.select, bus.ack);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.select !== 2'd3 || bus.out_valid !== 1'b0 || bus.ack !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_post actual busy=%b sel=%0d valid=%b ack=%b required busy=0 sel=3 valid=0 ack=0000",
               bus.busy, bus.select, bus.out_valid, bus.ack);
    end
    rst     = 1'b0;
    bus.req = 4'b0000;
    tick();
    $display("test_reset_mid: done");
  endtask

  task automatic test_burst1();
    logic [3:0] exp_ack;
    do_reset();
    bus1.out_ready = 1'b1;
    bus1.req       = 4'b0101;
    for (int c = 0; c < 8; c++) begin
      settle();
      if (c % 2 == 0)      exp_ack = 4'b0000;
      else if (c % 4 == 1) exp_ack = 4'b0001;
      else                 exp_ack = 4'b0100;
      checks++;
      if (bus1.ack !== exp_ack) begin
        failures++; $display("FAIL burst1_cycle%0d_ack actual=%b required=%b", c, bus1.ack, exp_ack);
      end
      tick();
    end
    bus1.req = 4'b0000;
    tick();
    $display("test_burst1: done");
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    bus.req        = 4'b0000;
    bus.in0        = 8'h00;
    bus.in1        = 8'h00;
    bus.in2        = 8'h00;
    bus.in3        = 8'h00;
    bus.out_ready  = 1'b0;
    bus1.req       = 4'b0000;
    bus1.in0       = 8'h10;
    bus1.in1       = 8'h21;
    bus1.in2       = 8'h32;
    bus1.in3       = 8'h43;
    bus1.out_ready = 1'b0;

    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_drop();
    test_reset_mid();
    test_burst1();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
